// File: rtl/xsvi_timing_pkg.sv
// Shared constants for the XSVI timing generator: standard timings and colour-bar palette.
package xsvi_timing_pkg;

    localparam int XSVI_RGB_W = 24;

    // 800x600@60 (40 MHz pixel clock), the CH7301 default mode
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    typedef logic [XSVI_RGB_W-1:0] rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/xsvi_axis_counter.sv
// One timing axis (H or V): counter over sync/back/active/front, 0 at sync leading edge.
// Count updates on the edge after inc; decodes are combinational from the count; no backpressure.
module xsvi_axis_counter #(
    parameter int SYNC   = 128,
    parameter int BACK   = 88,
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          in_sync,
    output logic          in_active
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam int START = SYNC + BACK;
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    // wrap marks the increment that returns the count to 0, so it can chain the next axis
    assign wrap      = inc && (cnt == LAST);
    assign in_sync   = (cnt < CW'(SYNC));
    assign in_active = (cnt >= CW'(START)) && (cnt < CW'(START + ACTIVE));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/xsvi_timing_gen.sv
// XSVI sync/DE/coordinate generator; every output registered one cycle after its counter state, no backpressure.
// Define XSVI_TPG_EN to add the xsvi_video_data colour-bar test pattern output.
module xsvi_timing_gen
    import xsvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FRONT  = SVGA_H_FRONT,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BACK   = SVGA_H_BACK,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FRONT  = SVGA_V_FRONT,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BACK   = SVGA_V_BACK,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 11
) (
    input  logic          xsvi_pix_clk,
    input  logic          Bus2IP_Reset,
    input  logic          enable,
    output logic          xsvi_h_sync,
    output logic          xsvi_v_sync,
    output logic          xsvi_video_active,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start
`ifdef XSVI_TPG_EN
    ,
    output logic [XSVI_RGB_W-1:0] xsvi_video_data
`endif
);

    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    logic          run;
    logic          live;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic          h_in_sync;
    logic          h_in_active;
    logic          v_in_sync;
    logic          v_in_active;
    logic          de_nxt;
    logic [CW-1:0] px_nxt;
    logic [CW-1:0] py_nxt;

    // run lags enable by one edge so the first enabled edge parks the counters at 0
    assign live = enable && run;

    xsvi_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .CW     (CW)
    ) u_h_cnt (
        .clk       (xsvi_pix_clk),
        .rst       (Bus2IP_Reset),
        .inc       (live),
        .clr       (!enable),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .in_sync   (h_in_sync),
        .in_active (h_in_active)
    );

    xsvi_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .CW     (CW)
    ) u_v_cnt (
        .clk       (xsvi_pix_clk),
        .rst       (Bus2IP_Reset),
        .inc       (h_wrap),
        .clr       (!enable),
        .cnt       (v_cnt),
        .wrap      (v_wrap_unused),
        .in_sync   (v_in_sync),
        .in_active (v_in_active)
    );

    always_comb begin
        de_nxt = live && h_in_active && v_in_active;
        px_nxt = de_nxt ? (h_cnt - CW'(H_START)) : '0;
        py_nxt = de_nxt ? (v_cnt - CW'(V_START)) : '0;
    end

    always_ff @(posedge xsvi_pix_clk) begin
        if (Bus2IP_Reset) begin
            run               <= 1'b0;
            xsvi_h_sync       <= ~HS_POL;
            xsvi_v_sync       <= ~VS_POL;
            xsvi_video_active <= 1'b0;
            pix_x             <= '0;
            pix_y             <= '0;
            line_start        <= 1'b0;
            frame_start       <= 1'b0;
        end else begin
            run               <= enable;
            xsvi_h_sync       <= (live && h_in_sync) ? HS_POL : ~HS_POL;
            xsvi_v_sync       <= (live && v_in_sync) ? VS_POL : ~VS_POL;
            xsvi_video_active <= de_nxt;
            pix_x             <= px_nxt;
            pix_y             <= py_nxt;
            line_start        <= live && (h_cnt == '0);
            frame_start       <= live && (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef XSVI_TPG_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic       in_bars;

    // Threshold search instead of a divide; columns past 8*BAR_W are the black remainder
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (px_nxt >= CW'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
        in_bars = (px_nxt < CW'(8 * BAR_W));
    end

    always_ff @(posedge xsvi_pix_clk) begin
        if (Bus2IP_Reset) begin
            xsvi_video_data <= '0;
        end else begin
            xsvi_video_data <= (de_nxt && in_bars) ? bar_colour(bar_idx) : BAR_BLACK;
        end
    end
`endif

endmodule

// File: doc/xsvi_timing_gen.md
# xsvi_timing_gen

Parametrised XSVI video timing generator for the CH7301 HDMI path. It produces horizontal/vertical sync, data-enable and active-pixel coordinates for any resolution and sync polarity, which generalises the fixed 800x600 counter pair used today. It sits between the pixel source (frame ROM/game renderer) and `user_logic`, clocked on the pixel clock. It starts only once the CH7301 I2C init reports done.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FRONT`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BACK`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FRONT`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BACK`, 23, vertical back porch (lines)
- `HS_POL`, 0, asserted level of `xsvi_h_sync` (0 = active-low)
- `VS_POL`, 0, asserted level of `xsvi_v_sync`
- `CW`, 11, counter and coordinate width; must hold `H_TOTAL-1` and `V_TOTAL-1`

Ports:
- `xsvi_pix_clk` in 1: pixel clock; the only clock.
- `Bus2IP_Reset` in 1: synchronous reset, active-high.
- `enable` in 1: run enable, driven by CH7301 init `done`.
- `xsvi_h_sync` out 1: horizontal sync, polarity `HS_POL`.
- `xsvi_v_sync` out 1: vertical sync, polarity `VS_POL`.
- `xsvi_video_active` out 1: data enable.
- `pix_x` out CW: active column, 0..H_ACTIVE-1.
- `pix_y` out CW: active row, 0..V_ACTIVE-1.
- `line_start` out 1: one-cycle pulse at h_cnt==0.
- `frame_start` out 1: one-cycle pulse at h_cnt==0 && v_cnt==0.
- `xsvi_video_data` out 24: test-pattern RGB. Present only with `XSVI_TPG_EN`.

## Operation
- Totals: `H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT`, `V_TOTAL` likewise. Line order is sync, back porch, active, front porch, with count 0 at the sync leading edge.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments only when `h_cnt==H_TOTAL-1` and wraps 0 after V_TOTAL-1. The simultaneous H and V wrap takes both counters to 0 on the same edge.
- Sync: h asserted while `h_cnt < H_SYNC`. v asserted while `v_cnt < V_SYNC`, and it changes aligned to `h_cnt==0`.
- Active region: `H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE`, ANDed with the equivalent vertical range.
- Coordinates: `pix_x = h_cnt-(H_SYNC+H_BACK)` and `pix_y = v_cnt-(V_SYNC+V_BACK)`, truncated to CW. Outside the active region both are forced to 0.
- Enable low: both counters are held at 0 and all outputs are at their inactive/zero level. Syncs idle at `~HS_POL` and `~VS_POL`.
- Enable deasserted mid-frame: counters return to 0 on the next edge. Re-assertion always starts a fresh frame.
- Reset has priority over enable. On reset: counters 0, syncs inactive, `xsvi_video_active`, `pix_x`, `pix_y`, `line_start`, `frame_start` all 0, and `xsvi_video_data` 0.

## Timing
- All outputs are registered, with one cycle of latency from the counter state that decodes them. All outputs of one counter value appear on the same edge, so there is no skew between sync, DE and coordinates.
- After `enable` rises:
  - edge 1 loads counter 0;
  - edge 2 presents `frame_start=1`, `line_start=1` and asserted syncs.
- Downstream pixel sources must produce data for (`pix_x`,`pix_y`) with zero additional latency, or re-register DE/syncs themselves.
- At the default parameters, with a 40 MHz clock: 1056x628 = 663168 cycles/frame, about 60.3 Hz.

## Configuration
- `XSVI_TPG_EN` defined:
  - `xsvi_video_data` outputs 8 vertical colour bars, each `H_ACTIVE/8` pixels wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Any remainder pixels at the right edge are black.
  - Data is registered in the same stage as DE and is 0 whenever DE is 0.
- `XSVI_TPG_EN` undefined:
  - the port and the bar logic are absent;
  - the pixel source drives `xsvi_video_data`.

## Structure
- Package `xsvi_timing_pkg` holds:
  - the default timing constants (800x600@60, plus a 640x480@60 set);
  - the 24-bit bar colour constants;
  - `XSVI_RGB_W = 24`.
- Sub-module `xsvi_axis_counter` is one axis counter, instantiated once for H and once for V. Its parameters are `SYNC`/`BACK`/`ACTIVE`/`FRONT`/`CW`. Its ports are `inc`, `clr`, `cnt`, `wrap`, `in_sync` and `in_active`.

## Test plan
Small bench parameters (H 3/2/8/2 = 15, V 2/1/4/1 = 8, 120 cycles/frame):
- Reset, then enable=1 → the first `frame_start` comes 2 edges after enable and repeats every 120 cycles. `line_start` repeats every 15 cycles.
- Per line (sync low) → `xsvi_h_sync` is 0 for 3 cycles then 1 for 12. DE is high for exactly 8 cycles, starting 5 cycles after the sync edge. `pix_x` steps 0..7.
- Frame → `xsvi_v_sync` is 0 for lines 0-1. DE is active on lines 3-6 only, and `pix_y` equals 0..3 there.
- HS_POL=1, VS_POL=1 → sync waveforms are inverted. Idle level with enable=0 is 0.
- Drop enable at v_cnt=5, h_cnt=9, then re-enable → outputs go inactive the next cycle. After re-enable, a fresh `frame_start` appears 2 edges later.
- With `XSVI_TPG_EN` (H_ACTIVE=16) → data is FFFFFF at `pix_x` 0-1, FFFF00 at 2-3, and so on through 000000 at 14-15. Data is 0 outside DE.
